sim_skid_buffer: RTL and testbench

//  Registered ready/valid buffer stage. It is the sequential counterpart of the plain wire

---
 rtl/sim_skid_buffer_pkg.sv | 11 +
 rtl/sim_skid_buffer.sv | 95 +++++++++
 tb/tb_sim_skid_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sim_skid_buffer_pkg.sv
// Shared definitions for the simulation misc ready/valid stages.
// The state encoding doubles as the occupancy count so stages can export it directly.
package sim_skid_buffer_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] EMPTY = 2'd0;
    localparam logic [STATE_W-1:0] ONE   = 2'd1;
    localparam logic [STATE_W-1:0] FULL  = 2'd2;

endpackage

// File: rtl/sim_skid_buffer.sv
// Registered ready/valid stage with a 2-entry skid: cuts data, valid and ready paths while
// sustaining one beat per cycle. All outputs come straight from flops.
module sim_skid_buffer
    import sim_skid_buffer_pkg::*;
#(
    parameter int                 BW_DATA    = 32,
    parameter logic [BW_DATA-1:0] RESET_DATA = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BW_DATA-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BW_DATA-1:0] m_data,
    output logic [1:0]         occupancy
);

    logic [STATE_W-1:0] state;
    logic [BW_DATA-1:0] main_q;
    logic [BW_DATA-1:0] skid_q;
    logic               accept;
    logic               consume;

    assign accept  = s_valid & s_ready;
    assign consume = m_valid & m_ready;

    // NOTE: every register here is assigned with <= so that all of them see the
    // pre-edge values of state/main_q/skid_q regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            // NOTE: skid_q is deliberately not reset; it is only read while FULL,
            // and FULL is reachable only after skid_q has been written.
            state   <= EMPTY;
            main_q  <= RESET_DATA;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state   <= ONE;
                        main_q  <= s_data;
                        m_valid <= 1'b1;
                    end
                end
                ONE: begin
                    case ({accept, consume})
                        2'b11: main_q <= s_data;
                        2'b10: begin
                            state   <= FULL;
                            skid_q  <= s_data;
                            s_ready <= 1'b0;
                        end
                        2'b01: begin
                            state   <= EMPTY;
                            m_valid <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    // s_ready is low here, so s_valid cannot cause an accept.
                    if (consume) begin
                        state   <= ONE;
                        main_q  <= skid_q;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    m_valid <= 1'b0;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

    assign m_data    = main_q;
    assign occupancy = state;

`ifdef SIM
    a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({s_valid, m_ready}));

    a_no_accept_full: assert property (@(posedge clk) disable iff (rst || clear)
        (state == FULL) |-> !s_ready);

    a_stall_stable: assert property (@(posedge clk) disable iff (rst || clear)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
`endif

endmodule

// File: tb/tb_sim_skid_buffer.sv
// Directed and randomized bench for sim_skid_buffer with a FIFO reference model.
module tb_sim_skid_buffer;

    localparam int              BW      = 32;
    localparam logic [BW-1:0]   RST_VAL = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [BW-1:0] m_data;
    logic [1:0]    occupancy;

    int            n_vec = 0;
    int            n_err = 0;
    logic [BW-1:0] model_q[$];
    logic [BW-1:0] out_log[$];

    always #5 clk = ~clk;

    sim_skid_buffer #(
        .BW_DATA    (BW),
        .RESET_DATA (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: transfers are decided from pre-edge values, outputs are checked 1ns after the edge.
    task automatic cycle();
        bit            acc;
        bit            con;
        bit            flush;
        logic [BW-1:0] din;
        logic [BW-1:0] dout;
        acc   = (s_valid === 1'b1) && (s_ready === 1'b1);
        con   = (m_valid === 1'b1) && (m_ready === 1'b1);
        flush = (rst === 1'b1) || (clear === 1'b1);
        din   = s_data;
        dout  = m_data;
        @(posedge clk);
        #1;
        if (flush) begin
            model_q.delete();
        end else begin
            if (con) begin
                out_log.push_back(dout);
                if (model_q.size() > 0) void'(model_q.pop_front());
            end
            if (acc) model_q.push_back(din);
        end
        check("model_occ", 32'(occupancy), 32'(model_q.size()));
        check("model_s_ready", 32'(s_ready), 32'(model_q.size() < 2));
        check("model_m_valid", 32'(m_valid), 32'(model_q.size() > 0));
        if (model_q.size() > 0) check("model_m_data", m_data, model_q[0]);
    endtask

    initial begin
        rst     = 1'b1;
        clear   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h77;
        m_ready = 1'b0;

        // Reset held two cycles with a beat offered
        cycle();
        cycle();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_m_data", m_data, RST_VAL);
        rst     = 1'b0;
        s_valid = 1'b0;
        cycle();
        check("rst_no_accept", 32'(occupancy), 32'd0);

        // Streaming 0x01..0x10 with m_ready high: one beat out per cycle
        out_log.delete();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            cycle();
            check("stream_m_valid", 32'(m_valid), 32'd1);
            check("stream_m_data", m_data, 32'(i));
            check("stream_occ", 32'(occupancy), 32'd1);
        end
        s_valid = 1'b0;
        cycle();
        check("stream_drained", 32'(occupancy), 32'd0);
        check("stream_count", 32'(out_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < out_log.size(); i++)
            check("stream_order", out_log[i], 32'(i + 1));

        // Backpressure: 0xA, 0xB fill the buffer, 0xC waits upstream
        out_log.delete();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hA;
        cycle();
        check("bp_occ1", 32'(occupancy), 32'd1);
        check("bp_ready1", 32'(s_ready), 32'd1);
        s_data = 32'hB;
        cycle();
        check("bp_occ2", 32'(occupancy), 32'd2);
        check("bp_ready2", 32'(s_ready), 32'd0);
        s_data = 32'hC;
        cycle();
        cycle();
        check("bp_hold_occ", 32'(occupancy), 32'd2);
        check("bp_hold_data", m_data, 32'hA);
        m_ready = 1'b1;
        cycle();
        check("bp_pop_a", m_data, 32'hB);
        check("bp_pop_a_occ", 32'(occupancy), 32'd1);
        cycle();
        check("bp_acc_c", m_data, 32'hC);
        s_valid = 1'b0;
        cycle();
        check("bp_empty", 32'(occupancy), 32'd0);
        check("bp_count", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            check("bp_out0", out_log[0], 32'hA);
            check("bp_out1", out_log[1], 32'hB);
            check("bp_out2", out_log[2], 32'hC);
        end

        // Random traffic against the reference model
        for (int i = 0; i < 10000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            cycle();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("rand_drained", 32'(occupancy), 32'd0);

        // Clear while FULL drops both held beats
        out_log.delete();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h5;
        cycle();
        s_data = 32'h6;
        cycle();
        check("clr_full", 32'(occupancy), 32'd2);
        clear   = 1'b1;
        m_ready = 1'b1;
        s_data  = 32'hEE;
        cycle();
        clear = 1'b0;
        check("clr_m_valid", 32'(m_valid), 32'd0);
        check("clr_occ", 32'(occupancy), 32'd0);
        check("clr_s_ready", 32'(s_ready), 32'd1);
        check("clr_m_data", m_data, RST_VAL);
        s_data = 32'h7;
        cycle();
        check("clr_next", m_data, 32'h7);
        s_valid = 1'b0;
        cycle();
        check("clr_count", 32'(out_log.size()), 32'd1);
        if (out_log.size() == 1) check("clr_out", out_log[0], 32'h7);

        // Simultaneous accept and consume in ONE
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h8;
        cycle();
        check("sim_one", 32'(occupancy), 32'd1);
        m_ready = 1'b1;
        s_data  = 32'h9;
        cycle();
        check("sim_occ", 32'(occupancy), 32'd1);
        check("sim_data", m_data, 32'h9);
        s_valid = 1'b0;
        cycle();
        check("sim_empty", 32'(occupancy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
